// File: rtl/grant_pkg.sv
// Shared constants and FSM state type for the grant scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grant_pkg;
  localparam int NUM_REQ      = 16;
  localparam int ID_W         = 4;
  localparam int HOLD_W       = 4;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;
endpackage

// File: rtl/onehot_to_bin.sv
// Encodes a one-hot (or all-zero) grant vector into its binary lane index.
// Latency: combinational.
// Backpressure: none; output is undefined for multi-hot input.
module onehot_to_bin
  import grant_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) bin = bin | ID_W'(i);
    end
  end

endmodule

// File: rtl/grant_scheduler.sv
// Round-robin single-owner grant of a shared resource with done/timeout release.
// Latency: request seen in IDLE at edge t -> registered grant after edge t+1.
// Backpressure: none; new requests wait in IDLE, owner holds until done_w or MAX_HOLD.
module grant_scheduler #(
  parameter int NUM_REQ  = grant_pkg::NUM_REQ,
  parameter int MAX_HOLD = grant_pkg::MAX_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_w,
  input  logic                     done_w,
  output logic [NUM_REQ-1:0]       gnt_w,
  output logic [grant_pkg::ID_W-1:0] gnt_id_w,
  output logic                     gnt_valid_w,
  output logic                     timeout_w
);
  import grant_pkg::*;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  req_rot, pick_oh;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     pick_off, pick_id, owner_id;
  logic                timeout_q, timeout_d;
  logic                pick_vld, expire;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rot[i] = req_w[ID_W'(i) + rr_ptr_q];
    end
  end

  always_comb begin
    pick_off = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off = ID_W'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_id = pick_off + rr_ptr_q;
  assign pick_oh = NUM_REQ'(1) << pick_id;
  assign expire  = (hold_q == HOLD_W'(MAX_HOLD));

  onehot_to_bin u_onehot_to_bin (
    .onehot (gnt_q),
    .bin    (owner_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      hold_q    <= '0;
      rr_ptr_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      rr_ptr_q  <= rr_ptr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   if (done_w || expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; done_w wins over expiry.
  always_comb begin
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = pick_vld ? pick_oh : '0;
        hold_d = pick_vld ? HOLD_W'(1) : '0;
      end
      GRANT: begin
        if (done_w || expire) begin
          gnt_d     = '0;
          hold_d    = '0;
          timeout_d = !done_w;
          rr_ptr_d  = owner_id + ID_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_d  = '0;
        hold_d = '0;
      end
    endcase
  end

  assign gnt_w       = gnt_q;
  assign gnt_id_w    = owner_id;
  assign gnt_valid_w = |gnt_q;
  assign timeout_w   = timeout_q;

endmodule

// File: tb/tb_grant_scheduler.sv
// Directed vector table plus hand-written multi-cycle sequences for grant_scheduler.
module tb_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_w;
  logic        done_w;
  logic [15:0] gnt_w;
  logic [3:0]  gnt_id_w;
  logic        gnt_valid_w;
  logic        timeout_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] exp_gnt;
    logic [3:0]  exp_id;
    logic        exp_vld;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  grant_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_w       (req_w),
    .done_w      (done_w),
    .gnt_w       (gnt_w),
    .gnt_id_w    (gnt_id_w),
    .gnt_valid_w (gnt_valid_w),
    .timeout_w   (timeout_w)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [15:0] q, input logic d,
                     input logic [15:0] eg, input logic [3:0] ei,
                     input logic ev, input logic et);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d;
    v.exp_gnt = eg; v.exp_id = ei; v.exp_vld = ev; v.exp_to = et;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [15:0] q, input logic d);
    rst_n  = r;
    req_w  = q;
    done_w = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] eg, input logic [3:0] ei,
                       input logic ev, input logic et);
    checks++;
    if (gnt_w !== eg || gnt_id_w !== ei || gnt_valid_w !== ev || timeout_w !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
               name, gnt_w, gnt_id_w, gnt_valid_w, timeout_w, eg, ei, ev, et);
    end
  endtask

  initial begin
    logic [3:0]  eid;
    logic [15:0] eg;

    rst_n = 1'b0; req_w = '0; done_w = 1'b0;

    // Reset, idle, basic grant/release, owner drop, done in IDLE/RELEASE, wrap search.
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(1, 16'h0024, 0, 16'h0004, 2, 1, 0);
    add(1, 16'h0024, 0, 16'h0004, 2, 1, 0);
    add(1, 16'h0024, 0, 16'h0004, 2, 1, 0);
    add(1, 16'h0024, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0024, 0, 16'h0000, 0, 0, 0);
    add(1, 16'h0024, 0, 16'h0020, 5, 1, 0);
    add(1, 16'h0000, 0, 16'h0020, 5, 1, 0);
    add(1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0011, 0, 16'h0001, 0, 1, 0);
    add(1, 16'h0002, 0, 16'h0001, 0, 1, 0);
    add(1, 16'h0002, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0002, 0, 16'h0000, 0, 0, 0);
    add(1, 16'h0002, 0, 16'h0002, 1, 1, 0);
    add(1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_id,
            vecs[i].exp_vld, vecs[i].exp_to);
    end

    // Fairness: all lanes requesting, done on 2nd GRANT cycle.
    step(0, 16'h0000, 0);
    check("fair_reset", 16'h0000, 0, 0, 0);
    step(1, 16'hFFFF, 0);
    check("fair_g0", 16'h0001, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      eid = 4'(k);
      eg  = 16'h0001 << eid;
      step(1, 16'hFFFF, 0);
      check($sformatf("fair_hold%0d", k), eg, eid, 1, 0);
      step(1, 16'hFFFF, 1);
      check($sformatf("fair_rel%0d", k), 16'h0000, 0, 0, 0);
      step(1, 16'hFFFF, 0);
      check($sformatf("fair_idle%0d", k), 16'h0000, 0, 0, 0);
      eid = 4'(k + 1);
      eg  = 16'h0001 << eid;
      step(1, 16'hFFFF, 0);
      check($sformatf("fair_g%0d", k + 1), eg, eid, 1, 0);
    end

    // Expiry: lane 15 holds for exactly 15 cycles, then timeout pulse, regrant.
    step(0, 16'h0000, 0);
    check("to_reset", 16'h0000, 0, 0, 0);
    step(1, 16'h8000, 0);
    check("to_c1", 16'h8000, 15, 1, 0);
    for (int c = 2; c <= 15; c++) begin
      step(1, 16'h8000, 0);
      check($sformatf("to_c%0d", c), 16'h8000, 15, 1, 0);
    end
    step(1, 16'h8000, 0);
    check("to_pulse", 16'h0000, 0, 0, 1);
    step(1, 16'h8000, 0);
    check("to_idle", 16'h0000, 0, 0, 0);
    step(1, 16'h8000, 0);
    check("to_regrant", 16'h8000, 15, 1, 0);

    // done_w on the expiry cycle counts as done: no timeout pulse.
    for (int c = 2; c <= 15; c++) begin
      step(1, 16'h8000, 0);
      check($sformatf("de_c%0d", c), 16'h8000, 15, 1, 0);
    end
    step(1, 16'h8000, 1);
    check("de_release", 16'h0000, 0, 0, 0);
    step(1, 16'h0000, 0);
    check("de_idle", 16'h0000, 0, 0, 0);

    // Reset mid-grant drops the grant immediately and clears rr_ptr.
    step(1, 16'h0008, 0);
    check("mr_g3", 16'h0008, 3, 1, 0);
    step(1, 16'h0000, 1);
    check("mr_rel3", 16'h0000, 0, 0, 0);
    step(1, 16'h0000, 0);
    check("mr_idle", 16'h0000, 0, 0, 0);
    step(1, 16'h0081, 0);
    check("mr_g7", 16'h0080, 7, 1, 0);
    for (int c = 2; c <= 4; c++) begin
      step(1, 16'h0081, 0);
      check($sformatf("mr_c%0d", c), 16'h0080, 7, 1, 0);
    end
    step(0, 16'h0081, 0);
    check("mr_reset", 16'h0000, 0, 0, 0);
    step(1, 16'h0081, 0);
    check("mr_after", 16'h0001, 0, 1, 0);
    step(1, 16'h0081, 0);
    check("mr_hold", 16'h0001, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
